// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one multi-cycle GCD core among NUM_REQ
// requesters, with a timeout watchdog and a single tagged response channel.
module gcd_rr_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           core_start_o,
  output logic [DATA_WIDTH-1:0]          core_a_o,
  output logic [DATA_WIDTH-1:0]          core_b_o,
  output logic                           core_abort_o,
  input  logic                           core_done_i,
  input  logic [DATA_WIDTH-1:0]          core_result_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_WIDTH-1:0]            rsp_id_o,
  output logic [DATA_WIDTH-1:0]          rsp_gcd_o,
  output logic                           rsp_err_o,
  output logic                           busy_o
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                    start_q, start_d, abort_q, abort_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_gcd_q, rsp_gcd_d;
  logic                    busy_q, busy_d;

  logic                    gnt_found;
  logic [ID_WIDTH-1:0]     gnt_id, scan_id;
  logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[k] = req_b_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or above ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr_q) + i >= NUM_REQ) scan_id = ID_WIDTH'(int'(ptr_q) + i - NUM_REQ);
      else                            scan_id = ID_WIDTH'(int'(ptr_q) + i);
      if (!gnt_found && req_valid_i[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  // Handshakes: a request transfers in the cycle req_valid_i[k] && req_ready_o[k];
  // a response transfers in the cycle rsp_valid_o && rsp_ready_i, and rsp_* hold until then.
  assign req_ready_o = (state_q == S_IDLE && gnt_found && !reset_i)
                       ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    rsp_gcd_d   = rsp_gcd_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d = S_ISSUE;
          id_d    = gnt_id;
          a_d     = a_arr[gnt_id];
          b_d     = b_arr[gnt_id];
          ptr_d   = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (core_done_i) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
          rsp_gcd_d   = core_result_i;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_gcd_d   = '0;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 2)) begin
          // Abort is registered, so it is launched one cycle early to land in the
          // final WAIT cycle; a done arriving in that cycle still completes normally.
          abort_d = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gcd_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gcd_q   <= rsp_gcd_d;
      busy_q      <= busy_d;
    end
  end

  assign core_start_o = start_q;
  assign core_abort_o = abort_q;
  assign core_a_o     = a_q;
  assign core_b_o     = b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_gcd_o    = rsp_gcd_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: table-driven transactions, directed corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_gcd_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic [N-1:0]      req_valid_i = '0;
  logic [N*DW-1:0]   req_a_i = '0;
  logic [N*DW-1:0]   req_b_i = '0;
  logic [N-1:0]      req_ready_o;
  logic              core_start_o, core_abort_o;
  logic [DW-1:0]     core_a_o, core_b_o;
  logic              core_done_i = 1'b0;
  logic [DW-1:0]     core_result_i = '0;
  logic              rsp_valid_o, rsp_err_o, busy_o;
  logic              rsp_ready_i = 1'b1;
  logic [1:0]        rsp_id_o;
  logic [DW-1:0]     rsp_gcd_o;

  gcd_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(2), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_ready_o(req_ready_o),
    .core_start_o(core_start_o), .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_abort_o(core_abort_o), .core_done_i(core_done_i), .core_result_i(core_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int n_grant = 0;
  int n_rsp = 0;
  int grant_log[$];
  logic [18:0] exp_q[$];

  int cyc = 0, m_ptr = 0, m_id = 0, grant_cyc = -10, m_rsp_cyc = -1, m_abort_cyc = -1;
  int cd = 0, lat = 0, core_lat = 1, eg = -1;
  bit m_busy = 0, was_busy = 0, fail_to = 0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
  int last_id = 0;
  logic [DW-1:0] last_gcd = '0;
  logic last_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int gcd_f(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [DW-1:0] rand_op();
    int f;
    f = $urandom_range(1, 50);
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'(f * $urandom_range(0, 1200));
  endfunction

  // Reference model + core model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset_i) begin
      m_ptr = 0; m_busy = 0; m_a = '0; m_b = '0;
      m_rsp_cyc = -1; m_abort_cyc = -1; cd = 0;
      exp_q.delete();
      core_done_i = 1'b0;
    end else begin
      was_busy = m_busy;
      check("core_start", core_start_o, m_busy && (cyc == grant_cyc + 1));
      check("core_a", core_a_o, m_a);
      check("core_b", core_b_o, m_b);
      check("core_abort", core_abort_o, cyc == m_abort_cyc);
      check("busy", busy_o, m_busy);
      check("rsp_valid", rsp_valid_o, m_busy && m_rsp_cyc >= 0 && cyc >= m_rsp_cyc);
      if (rsp_valid_o && exp_q.size() > 0) begin
        check("rsp_fields", {rsp_id_o, rsp_err_o, rsp_gcd_o}, exp_q[0]);
        if (rsp_ready_i) begin
          last_id = int'(rsp_id_o); last_gcd = rsp_gcd_o; last_err = rsp_err_o;
          void'(exp_q.pop_front());
          m_busy = 0; m_rsp_cyc = -1; m_abort_cyc = -1;
          n_rsp++;
        end
      end
      // GCD core: done after lat WAIT cycles; lat==0 never answers
      core_done_i   = 1'b0;
      core_result_i = 16'($urandom);
      if (core_start_o && m_busy) begin
        lat = (core_lat < 0) ? $urandom_range(0, TO + 2) : core_lat;
        cd = lat;
        m_res = 16'(gcd_f(int'(m_a), int'(m_b)));
        fail_to = (lat == 0) || (lat > TO);
        m_abort_cyc = (lat == 0 || lat >= TO) ? grant_cyc + 1 + TO : -1;
        m_rsp_cyc = grant_cyc + 2 + (fail_to ? TO : lat);
        exp_q.push_back({2'(m_id), fail_to, fail_to ? 16'd0 : m_res});
      end else if (cd > 0) begin
        if (cd == 1) begin
          core_done_i = 1'b1;
          core_result_i = m_res;
        end
        cd--;
      end
      // round-robin arbitration over the requests present this cycle
      eg = -1;
      if (!was_busy)
        for (int i = 0; i < N; i++)
          if (eg < 0 && req_valid_i[(m_ptr + i) % N]) eg = (m_ptr + i) % N;
      check("req_ready", req_ready_o, (eg >= 0) ? (64'd1 << eg) : 64'd0);
      if (eg >= 0) begin
        m_busy = 1; m_id = eg; grant_cyc = cyc;
        m_a = req_a_i[eg*DW +: DW];
        m_b = req_b_i[eg*DW +: DW];
        m_ptr = (eg + 1) % N;
        grant_log.push_back(eg);
        n_grant++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 0);
    check({tag, "_core_start"}, core_start_o, 0);
    check({tag, "_core_abort"}, core_abort_o, 0);
    check({tag, "_core_ab"}, {core_a_o, core_b_o}, 0);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rsp_fields"}, {rsp_id_o, rsp_err_o, rsp_gcd_o}, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    step();
    step();
    check_reset_outs("rst");
    reset_i = 1'b0;
    step();
  endtask

  task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a_i[id*DW +: DW] = a;
    req_b_i[id*DW +: DW] = b;
    req_valid_i[id] = 1'b1;
  endtask

  task automatic wait_grants(input int target, input int bound);
    int k;
    k = 0;
    while (grant_log.size() < target && k < bound) begin
      step();
      k++;
    end
    check("grant_wait", grant_log.size() >= target, 1);
  endtask

  task automatic do_txn(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input int l);
    int r0, k;
    core_lat = l;
    set_req(id, a, b);
    wait_grants(grant_log.size() + 1, 20);
    req_valid_i[id] = 1'b0;
    r0 = n_rsp;
    k = 0;
    while (n_rsp == r0 && k < 40) begin
      step();
      k++;
    end
    check("rsp_wait", n_rsp != r0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    while ((busy_o || rsp_valid_o) && k < 100) begin
      step();
      k++;
    end
    check("drain_idle", busy_o, 0);
    check("drain_pending", exp_q.size(), 0);
    step();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int lat;
    logic [DW-1:0] gcd;
    logic err;
  } vec_t;

  vec_t tbl[8];
  int g0, r0, k;
  logic [18:0] snap;

  initial begin
    tbl[0] = '{2, 16'd48, 16'd18, 5, 16'd6, 1'b0};
    tbl[1] = '{0, 16'd100, 16'd75, 1, 16'd25, 1'b0};
    tbl[2] = '{1, 16'd0, 16'd7, 2, 16'd7, 1'b0};
    tbl[3] = '{3, 16'd17, 16'd0, 3, 16'd17, 1'b0};
    tbl[4] = '{0, 16'd0, 16'd0, 2, 16'd0, 1'b0};
    tbl[5] = '{1, 16'd13, 16'd8, 0, 16'd0, 1'b1};
    tbl[6] = '{2, 16'd65535, 16'd255, TO, 16'd255, 1'b0};
    tbl[7] = '{3, 16'd12, 16'd18, TO + 1, 16'd0, 1'b1};

    do_reset();

    // table-driven single transactions, incl. zero operands, timeout and done-at-deadline
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].lat);
      check($sformatf("tbl%0d_id", i), last_id, tbl[i].id);
      check($sformatf("tbl%0d_gcd", i), last_gcd, tbl[i].gcd);
      check($sformatf("tbl%0d_err", i), last_err, tbl[i].err);
    end

    // round-robin fairness with all requesters pending from reset
    do_reset();
    core_lat = 2;
    for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
    g0 = grant_log.size();
    wait_grants(g0 + 8, 200);
    req_valid_i = '0;
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_order%0d", i), (g0 + i < grant_log.size()) ? grant_log[g0 + i] : -1, i % N);
    drain();

    // pointer wrap: ptr=1, only 3 and 0 pending
    do_reset();
    do_txn(0, 16'd9, 16'd6, 1);
    core_lat = 1;
    set_req(3, 16'd21, 16'd14);
    set_req(0, 16'd8, 16'd12);
    g0 = grant_log.size();
    wait_grants(g0 + 2, 60);
    req_valid_i = '0;
    check("wrap_first", (g0 < grant_log.size()) ? grant_log[g0] : -1, 3);
    check("wrap_second", (g0 + 1 < grant_log.size()) ? grant_log[g0 + 1] : -1, 0);
    drain();

    // response backpressure with other requests waiting
    do_reset();
    rsp_ready_i = 1'b0;
    core_lat = 2;
    set_req(1, 16'd36, 16'd24);
    wait_grants(grant_log.size() + 1, 20);
    req_valid_i[1] = 1'b0;
    set_req(2, 16'd15, 16'd10);
    set_req(3, 16'd7, 16'd5);
    k = 0;
    while (!rsp_valid_o && k < 30) begin
      step();
      k++;
    end
    snap = {rsp_id_o, rsp_err_o, rsp_gcd_o};
    check("bp_rsp", snap, {2'd1, 1'b0, 16'd12});
    for (int i = 0; i < 10; i++) begin
      check("bp_stable", {rsp_valid_o, rsp_id_o, rsp_err_o, rsp_gcd_o}, {1'b1, snap});
      check("bp_no_ready", req_ready_o, 0);
      check("bp_no_start", core_start_o, 0);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    check("bp_next_grant", req_ready_o, 4'b0100);
    g0 = grant_log.size();
    wait_grants(g0 + 2, 60);
    drain();

    // reset in the middle of WAIT
    do_reset();
    core_lat = 0;
    set_req(2, 16'd10, 16'd4);
    wait_grants(grant_log.size() + 1, 20);
    req_valid_i = '0;
    step();
    step();
    check("mid_in_wait", busy_o, 1);
    r0 = n_rsp;
    req_valid_i = 4'b1010;
    #3;
    reset_i = 1'b1;
    #1;
    check_reset_outs("async");
    step();
    step();
    g0 = grant_log.size();
    reset_i = 1'b0;
    wait_grants(g0 + 1, 20);
    req_valid_i = '0;
    check("mid_no_rsp", n_rsp - r0, 0);
    check("mid_ptr_restart", (g0 < grant_log.size()) ? grant_log[g0] : -1, 1);
    core_lat = 1;
    drain();

    // randomized traffic: valid toggling, withdrawals, backpressure, random latency
    do_reset();
    core_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int q = 0; q < N; q++) begin
        if (!req_valid_i[q]) begin
          if ($urandom_range(0, 3) == 0) set_req(q, rand_op(), rand_op());
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid_i[q] = 1'b0;
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    check("rand_activity", n_grant > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
